// File: rtl/oflow_buffer_fsm_read.sv
// MEM-buffer read sequencer: loads one set of current-frame bboxes into the PE array,
// then walks the previous-frame history lines one read_new_line request at a time.
module oflow_buffer_fsm_read #(
   parameter int PE_NUM          = 24,
   parameter int ADDR_LEN        = 8,
   parameter int SET_LEN         = 4,
   parameter int REMAIN_BBOX_LEN = 9
) (
   input  logic                       clk,
   input  logic                       reset_N,
   input  logic                       frame_start,
   input  logic                       start_read,
   input  logic                       read_new_line,
   input  logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes,
   input  logic [ADDR_LEN-1:0]        num_of_history_bboxes,
   output logic                       cur_rd_en,
   output logic [ADDR_LEN-1:0]        cur_rd_addr,
   output logic [PE_NUM-1:0]          pe_load_en,
   output logic                       hist_rd_en,
   output logic [ADDR_LEN-1:0]        hist_rd_addr,
   output logic                       hist_valid,
   output logic                       done_read,
   output logic                       done_history,
   output logic                       busy
);

   localparam int K_W = $clog2(PE_NUM + 1);

   typedef enum logic [2:0] {IDLE, READ_SET, FLUSH, LINE_READ, LINE_WAIT} state_t;

   state_t              state;
   logic [SET_LEN-1:0]  set_idx;
   logic [ADDR_LEN-1:0] line_idx;
   logic [ADDR_LEN-1:0] hist_cnt;
   logic [ADDR_LEN-1:0] base;
   logic [K_W-1:0]      k;
   logic [K_W-1:0]      n_set;
   logic [K_W-1:0]      n_req;
   logic [ADDR_LEN-1:0] base_req;

   function automatic logic [PE_NUM-1:0] pe_bit(input logic [K_W-1:0] idx);
      pe_bit = {{(PE_NUM-1){1'b0}}, 1'b1} << idx;
   endfunction

   assign n_req    = (counter_of_remain_bboxes > REMAIN_BBOX_LEN'(PE_NUM)) ?
                     K_W'(PE_NUM) : K_W'(counter_of_remain_bboxes);
   assign base_req = ADDR_LEN'(set_idx) * ADDR_LEN'(PE_NUM);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         state        <= IDLE;
         set_idx      <= '0;
         line_idx     <= '0;
         hist_cnt     <= '0;
         base         <= '0;
         k            <= '0;
         n_set        <= '0;
         cur_rd_en    <= 1'b0;
         cur_rd_addr  <= '0;
         pe_load_en   <= '0;
         hist_rd_en   <= 1'b0;
         hist_rd_addr <= '0;
         hist_valid   <= 1'b0;
         done_read    <= 1'b0;
         done_history <= 1'b0;
      end else begin
         // every output is a single-cycle strobe unless re-asserted below
         cur_rd_en    <= 1'b0;
         cur_rd_addr  <= '0;
         pe_load_en   <= '0;
         hist_rd_en   <= 1'b0;
         hist_rd_addr <= '0;
         hist_valid   <= 1'b0;
         done_read    <= 1'b0;
         done_history <= 1'b0;
         if (frame_start) begin
            state    <= IDLE;
            set_idx  <= '0;
            line_idx <= '0;
            k        <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_read) begin
                     n_set    <= n_req;
                     hist_cnt <= num_of_history_bboxes;
                     base     <= base_req;
                     k        <= '0;
                     if (n_req != '0) begin
                        state       <= READ_SET;
                        cur_rd_en   <= 1'b1;
                        cur_rd_addr <= base_req;
                     end else begin
                        state     <= FLUSH;
                        done_read <= 1'b1;
                        set_idx   <= set_idx + 1'b1;
                     end
                  end
               end
               READ_SET: begin
                  // read data for entry k returns now, so PE k latches it
                  pe_load_en <= pe_bit(k);
                  if (k == n_set - 1'b1) begin
                     state     <= FLUSH;
                     done_read <= 1'b1;
                     set_idx   <= set_idx + 1'b1;
                  end else begin
                     k           <= k + 1'b1;
                     cur_rd_en   <= 1'b1;
                     cur_rd_addr <= base + ADDR_LEN'(k) + 1'b1;
                  end
               end
               FLUSH: begin
                  k <= '0;
                  if (hist_cnt != '0) begin
                     state        <= LINE_READ;
                     line_idx     <= '0;
                     hist_rd_en   <= 1'b1;
                     hist_rd_addr <= '0;
                  end else begin
                     state        <= IDLE;
                     done_history <= 1'b1;
                  end
               end
               LINE_READ: begin
                  state      <= LINE_WAIT;
                  hist_valid <= 1'b1;
               end
               LINE_WAIT: begin
                  // a request coinciding with the data-valid cycle is dropped
                  if (read_new_line && !hist_valid) begin
                     if (line_idx == hist_cnt - 1'b1) begin
                        state        <= IDLE;
                        line_idx     <= '0;
                        done_history <= 1'b1;
                     end else begin
                        state        <= LINE_READ;
                        line_idx     <= line_idx + 1'b1;
                        hist_rd_en   <= 1'b1;
                        hist_rd_addr <= line_idx + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_oflow_buffer_fsm_read.sv
// Directed bench for oflow_buffer_fsm_read: set loads, history walks, empty sets,
// ignored requests, frame_start priority and asynchronous reset.
module tb_oflow_buffer_fsm_read;

   localparam int PE_NUM = 24;
   localparam int ADDR_LEN = 8;
   localparam int SET_LEN = 4;
   localparam int RB_LEN = 9;

   logic                clk = 1'b0;
   logic                reset_N;
   logic                frame_start;
   logic                start_read;
   logic                read_new_line;
   logic [RB_LEN-1:0]   counter_of_remain_bboxes;
   logic [ADDR_LEN-1:0] num_of_history_bboxes;
   logic                cur_rd_en;
   logic [ADDR_LEN-1:0] cur_rd_addr;
   logic [PE_NUM-1:0]   pe_load_en;
   logic                hist_rd_en;
   logic [ADDR_LEN-1:0] hist_rd_addr;
   logic                hist_valid;
   logic                done_read;
   logic                done_history;
   logic                busy;

   int n_checks = 0;
   int n_fail = 0;

   oflow_buffer_fsm_read #(
      .PE_NUM(PE_NUM), .ADDR_LEN(ADDR_LEN), .SET_LEN(SET_LEN), .REMAIN_BBOX_LEN(RB_LEN)
   ) dut (
      .clk(clk), .reset_N(reset_N), .frame_start(frame_start), .start_read(start_read),
      .read_new_line(read_new_line), .counter_of_remain_bboxes(counter_of_remain_bboxes),
      .num_of_history_bboxes(num_of_history_bboxes), .cur_rd_en(cur_rd_en),
      .cur_rd_addr(cur_rd_addr), .pe_load_en(pe_load_en), .hist_rd_en(hist_rd_en),
      .hist_rd_addr(hist_rd_addr), .hist_valid(hist_valid), .done_read(done_read),
      .done_history(done_history), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic ce, input logic [7:0] ca,
                           input logic [23:0] pe, input logic he, input logic [7:0] ha,
                           input logic hv, input logic dr, input logic dh, input logic bz);
      check({tag, ".cur_rd_en"},    32'(cur_rd_en),    32'(ce));
      check({tag, ".cur_rd_addr"},  32'(cur_rd_addr),  32'(ca));
      check({tag, ".pe_load_en"},   32'(pe_load_en),   32'(pe));
      check({tag, ".hist_rd_en"},   32'(hist_rd_en),   32'(he));
      check({tag, ".hist_rd_addr"}, 32'(hist_rd_addr), 32'(ha));
      check({tag, ".hist_valid"},   32'(hist_valid),   32'(hv));
      check({tag, ".done_read"},    32'(done_read),    32'(dr));
      check({tag, ".done_history"}, 32'(done_history), 32'(dh));
      check({tag, ".busy"},         32'(busy),         32'(bz));
      check({tag, ".rd_excl"},      32'(cur_rd_en & hist_rd_en), 32'd0);
   endtask

   // Issue start_read and follow the load through FLUSH and the first history read.
   task automatic run_set(input int remain, input int h, input int base, input int n,
                          input bit inject);
      logic [23:0] pe_exp;
      @(negedge clk);
      start_read = 1'b1;
      counter_of_remain_bboxes = RB_LEN'(remain);
      num_of_history_bboxes = ADDR_LEN'(h);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         pe_exp = (j == 0) ? 24'd0 : (24'd1 << (j - 1));
         chk_outs($sformatf("rd_b%0d_j%0d", base, j), 1'b1, 8'(base + j), pe_exp,
                  1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
         start_read = inject && (j == 5);
      end
      @(negedge clk);
      start_read = 1'b0;
      pe_exp = (n > 0) ? (24'd1 << (n - 1)) : 24'd0;
      chk_outs($sformatf("flush_b%0d", base), 1'b0, 8'd0, pe_exp,
               1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      if (h > 0) begin
         chk_outs("line0", 1'b0, 8'd0, 24'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
         read_new_line = inject;
         @(negedge clk);
         read_new_line = 1'b0;
         chk_outs("valid0", 1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      end else begin
         chk_outs("dhist_h0", 1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         @(negedge clk);
         chk_outs("idle_h0", 1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Starts at the hist_valid cycle of line 0; requests the remaining lines.
   task automatic hist_walk(input int h, input bit poke_valid);
      for (int i = 1; i <= h; i++) begin
         read_new_line = poke_valid && (i == 1);
         @(negedge clk);
         read_new_line = 1'b0;
         chk_outs($sformatf("wait%0d", i), 1'b0, 8'd0, 24'd0, 1'b0, 8'd0,
                  1'b0, 1'b0, 1'b0, 1'b1);
         read_new_line = 1'b1;
         @(negedge clk);
         read_new_line = 1'b0;
         if (i < h) begin
            chk_outs($sformatf("line%0d", i), 1'b0, 8'd0, 24'd0, 1'b1, 8'(i),
                     1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            chk_outs($sformatf("valid%0d", i), 1'b0, 8'd0, 24'd0, 1'b0, 8'd0,
                     1'b1, 1'b0, 1'b0, 1'b1);
         end else begin
            chk_outs("done_hist", 1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            read_new_line = 1'b1;
            @(negedge clk);
            read_new_line = 1'b0;
            chk_outs("extra_rnl", 1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         end
      end
   endtask

   initial begin
      reset_N = 1'b0;
      frame_start = 1'b0;
      start_read = 1'b0;
      read_new_line = 1'b0;
      counter_of_remain_bboxes = '0;
      num_of_history_bboxes = '0;
      repeat (2) @(negedge clk);
      chk_outs("reset", 1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_N = 1'b1;

      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk_outs("frame_start", 1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      run_set(50, 3, 0, 24, 1'b1);
      hist_walk(3, 1'b1);
      run_set(26, 1, 24, 24, 1'b0);
      hist_walk(1, 1'b0);
      run_set(2, 2, 48, 2, 1'b0);
      hist_walk(2, 1'b0);
      run_set(0, 0, 0, 0, 1'b0);

      @(negedge clk);
      frame_start = 1'b1;
      start_read = 1'b1;
      counter_of_remain_bboxes = 9'd5;
      num_of_history_bboxes = 8'd0;
      @(negedge clk);
      frame_start = 1'b0;
      start_read = 1'b0;
      chk_outs("fs_wins", 1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_set(5, 0, 0, 5, 1'b0);

      @(negedge clk);
      start_read = 1'b1;
      counter_of_remain_bboxes = 9'd24;
      num_of_history_bboxes = 8'd1;
      for (int j = 0; j <= 10; j++) begin
         @(negedge clk);
         start_read = 1'b0;
         chk_outs($sformatf("pre_rst_j%0d", j), 1'b1, 8'(24 + j),
                  (j == 0) ? 24'd0 : (24'd1 << (j - 1)),
                  1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      #2 reset_N = 1'b0;
      #1 chk_outs("async_rst", 1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_N = 1'b1;
      run_set(3, 0, 0, 3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/oflow_buffer_fsm_read.md
Name: oflow_buffer_fsm_read

Overview:
- Memory-side read sequencer for the MEM buffer; sits directly downstream of the core read FSM.
- On a `start_read` pulse, loads the current set of up to PE_NUM current-frame bboxes into the PE array, one bbox per PE, and returns a `done_read` pulse.
- Each `read_new_line` pulse then fetches the next previous-frame (history) bbox line, which is broadcast to all PEs for similarity scoring.
- Tracks the set index across a frame.

Parameters:
- PE_NUM, 24, number of processing elements / max bboxes per set
- ADDR_LEN, 8, MEM buffer address width (256 entries)
- SET_LEN, 4, set index width
- REMAIN_BBOX_LEN, 9, width of remaining-bbox count

Ports:
- clk  in  1  clock
- reset_N  in  1  asynchronous active-low reset
- frame_start  in  1  1-cycle pulse; clears set index and history line index
- start_read  in  1  1-cycle pulse from core read FSM; load current set
- read_new_line  in  1  1-cycle pulse from core read FSM; fetch next history line
- counter_of_remain_bboxes  in  REMAIN_BBOX_LEN  current-frame bboxes not yet loaded, sampled on start_read
- num_of_history_bboxes  in  ADDR_LEN  previous-frame bbox count, sampled on start_read
- cur_rd_en  out  1  current-frame buffer read enable
- cur_rd_addr  out  ADDR_LEN  current-frame buffer read address
- pe_load_en  out  PE_NUM  one-hot; PE k latches buffer read data this cycle
- hist_rd_en  out  1  history buffer read enable
- hist_rd_addr  out  ADDR_LEN  history buffer read address
- hist_valid  out  1  history read data valid for all PEs this cycle
- done_read  out  1  1-cycle pulse; set load complete
- done_history  out  1  1-cycle pulse; all history lines consumed for this set
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE, all outputs 0, set_idx = 0, line_idx = 0, k = 0.
- Buffer memories have 1-cycle synchronous read latency.
- On start_read in IDLE, latch:
  - n = min(counter_of_remain_bboxes, PE_NUM)
  - h = num_of_history_bboxes
  - base = set_idx*PE_NUM, truncated to ADDR_LEN
- States: IDLE, READ_SET, FLUSH, LINE_READ, LINE_WAIT.
- IDLE:
  - start_read with n > 0 -> READ_SET, k = 0.
  - start_read with n == 0 -> done_read pulses next cycle, no reads, then history handling as below.
- READ_SET:
  - Each cycle: cur_rd_en = 1, cur_rd_addr = base + k, k++.
  - pe_load_en bit (k-1) is asserted the following cycle, aligned to the data.
  - When k == n-1 is issued -> FLUSH.
- FLUSH (1 cycle):
  - Last pe_load_en bit asserted; done_read = 1 in the same cycle; set_idx++ (wraps modulo 2^SET_LEN).
  - Next state: h > 0 -> LINE_READ with line_idx = 0; h == 0 -> done_history pulses next cycle, then IDLE.
- LINE_READ (1 cycle):
  - hist_rd_en = 1, hist_rd_addr = line_idx.
  - Next cycle hist_valid = 1 and state -> LINE_WAIT.
- LINE_WAIT, on read_new_line:
  - line_idx == h-1 -> done_history = 1 next cycle, line_idx = 0, -> IDLE.
  - Otherwise line_idx++ -> LINE_READ.
- Ignored requests:
  - start_read outside IDLE is ignored (no queuing).
  - read_new_line outside LINE_WAIT is ignored, including the cycle hist_valid is high.
- frame_start:
  - Clears set_idx and line_idx from any state and forces IDLE next cycle.
  - All outputs go 0 next cycle, with no done pulses.
  - If coincident with start_read, frame_start wins; start_read is dropped.
- Reset asserted mid-operation returns to reset values immediately (asynchronous).
- Invariants:
  - At most one pe_load_en bit is high per cycle.
  - Bits >= n are never asserted for a set.
  - cur_rd_en and hist_rd_en are never high in the same cycle.

Test Plan:
- Full set: reset, frame_start, start_read with remain=50, h=3 -> cur_rd_addr 0..23 on 24 consecutive cycles; pe_load_en walks bit0..bit23 one cycle later; done_read coincides with bit23; hist_rd_addr=0, hist_valid next cycle.
- History walk: after the previous case, 2 read_new_line pulses -> hist_rd_addr 1 then 2, each followed by hist_valid; a 3rd pulse -> done_history 1 cycle later, busy=0; 4th pulse ignored.
- Partial last set: second start_read with remain=26, then third with remain=2 -> set 2 reads addr 48,49 only; pe_load_en bits 0,1 only; done_read after 2 reads.
- Empty cases: remain=0, h=0 -> done_read, then done_history, no cur_rd_en or hist_rd_en ever asserted.
- Illegal and simultaneous requests: start_read during READ_SET and read_new_line during LINE_READ are ignored, so the address sequence is unchanged; frame_start together with start_read -> stays IDLE, set_idx=0.
- Reset mid-READ_SET (k=10) -> all outputs 0 asynchronously; next start_read restarts at addr 0.
